// File: rtl/ccff_bist_pkg.sv
// ccff_bist_pkg
//   Shared types and helpers for the configuration-chain self-test.
//   - state_e   : BIST controller states
//   - mode_e    : pattern selection (single pulse / alternating)
//   - shift_len : number of SHIFT cycles for a given mode and chain geometry
//   - cnt_width : width of the SHIFT cycle counter
package ccff_bist_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        REPORT = 2'd2
    } state_e;

    typedef enum logic {
        MODE_PULSE = 1'b0,
        MODE_ALT   = 1'b1
    } mode_e;

    // Pattern length P is 1 for a single pulse, one full chain for alternating.
    function automatic int unsigned shift_len(input mode_e       m,
                                              input int unsigned chain_length,
                                              input int unsigned num_tail);
        int unsigned plen;
        plen = (m == MODE_ALT) ? chain_length : 1;
        return chain_length + plen + num_tail;
    endfunction

    // Wide enough for the longest test (alternating mode) with headroom.
    function automatic int unsigned cnt_width(input int unsigned chain_length,
                                              input int unsigned num_tail);
        return $clog2(2 * chain_length + num_tail + 1);
    endfunction

endpackage

// File: rtl/ccff_bist_if.sv
// ccff_bist_if
//   Control/status and chain-pin bundle for ccff_bist.
//   start, mode          : test request and pattern select
//   ccff_head, ccff_tail : drive into / return from the configuration chains
//   busy, done, pass     : test progress and verdict
//   err_count            : saturating count of cycles with any mismatch
//   err_chain_mask       : sticky per-chain mismatch flags
//   Modports: master = controller/fabric side, slave = BIST block.
interface ccff_bist_if #(
    parameter int unsigned NUM_CHAINS = 1,
    parameter int unsigned ERR_W      = 16
);
    logic                  start;
    logic                  mode;
    logic [NUM_CHAINS-1:0] ccff_head;
    logic [NUM_CHAINS-1:0] ccff_tail;
    logic                  busy;
    logic                  done;
    logic                  pass;
    logic [ERR_W-1:0]      err_count;
    logic [NUM_CHAINS-1:0] err_chain_mask;

    modport master (
        output start,
        output mode,
        output ccff_tail,
        input  ccff_head,
        input  busy,
        input  done,
        input  pass,
        input  err_count,
        input  err_chain_mask
    );

    modport slave (
        input  start,
        input  mode,
        input  ccff_tail,
        output ccff_head,
        output busy,
        output done,
        output pass,
        output err_count,
        output err_chain_mask
    );

endinterface

// File: rtl/ccff_bist_pattern.sv
// ccff_bist_pattern
//   Combinational pattern generator pat(idx) for the chain self-test.
//   idx     : position in the pattern stream
//   plen    : pattern length P; positions at or beyond P yield 0
//   mode    : MODE_PULSE -> 1, MODE_ALT -> ~idx[0] (1,0,1,0,...)
//   pat_bit : pattern bit for idx
module ccff_bist_pattern
    import ccff_bist_pkg::*;
#(
    parameter int unsigned CNT_W = 7
) (
    input  logic [CNT_W-1:0] idx,
    input  logic [CNT_W-1:0] plen,
    input  mode_e            mode,
    output logic             pat_bit
);

    always_comb begin
        pat_bit = 1'b0;
        if (idx < plen) begin
            pat_bit = (mode == MODE_ALT) ? ~idx[0] : 1'b1;
        end
    end

endmodule

// File: rtl/ccff_bist.sv
// ccff_bist
//   On-chip self-test for the fabric configuration chains, clocked by the
//   programming clock. A pattern is shifted into every chain head; each tail
//   must return the same pattern CHAIN_LENGTH cycles later, then NUM_TAIL
//   zeros.
//   prog_clk   : programming clock (only clock)
//   prog_reset : synchronous, active-high reset; aborts a running test
//   bus        : ccff_bist_if slave modport (start/mode in, chain head/tail,
//                busy/done/pass/err_count/err_chain_mask out)
module ccff_bist
    import ccff_bist_pkg::*;
#(
    parameter int unsigned NUM_CHAINS   = 1,
    parameter int unsigned CHAIN_LENGTH = 64,
    parameter int unsigned NUM_TAIL     = 2,
    parameter int unsigned ERR_W        = 16
) (
    input logic           prog_clk,
    input logic           prog_reset,
    ccff_bist_if.slave    bus
);

    localparam int unsigned CNT_W = cnt_width(CHAIN_LENGTH, NUM_TAIL);

    localparam logic [CNT_W-1:0] LEN_C      = CNT_W'(CHAIN_LENGTH);
    localparam logic [CNT_W-1:0] LAST_PULSE =
        CNT_W'(shift_len(MODE_PULSE, CHAIN_LENGTH, NUM_TAIL) - 1);
    localparam logic [CNT_W-1:0] LAST_ALT   =
        CNT_W'(shift_len(MODE_ALT, CHAIN_LENGTH, NUM_TAIL) - 1);

    state_e                state_q;
    state_e                state_d;
    logic [CNT_W-1:0]      cnt_q;
    logic [CNT_W-1:0]      cnt_d;
    logic [CNT_W-1:0]      last_c;
    logic                  accept;

    mode_e                 mode_q;
    mode_e                 mode_d;
    logic [CNT_W-1:0]      plen_q;
    logic [CNT_W-1:0]      plen_d;

    logic                  head_bit;
    logic                  exp_bit;
    logic [CNT_W-1:0]      k_idx;
    logic                  check_en;
    logic [NUM_CHAINS-1:0] mism;
    logic [NUM_CHAINS-1:0] mask_d;

    logic [NUM_CHAINS-1:0] head_q;
    logic [ERR_W-1:0]      err_q;
    logic [NUM_CHAINS-1:0] mask_q;
    logic                  pass_q;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign last_c = (mode_q == MODE_ALT) ? LAST_ALT : LAST_PULSE;

    // ------------------------------------------------------------------
    // FSM: next state and cycle counter
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    accept  = 1'b1;
                    state_d = SHIFT;
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                if (cnt_q == last_c) begin
                    state_d = REPORT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            REPORT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Mode for the head generator must be the incoming one on the accept
    // cycle, because the head register is loaded with pat(0) on that edge.
    assign mode_d = accept ? mode_e'(bus.mode) : mode_q;
    assign plen_d = (mode_d == MODE_ALT) ? LEN_C : CNT_W'(1);
    assign plen_q = (mode_q == MODE_ALT) ? LEN_C : CNT_W'(1);

    // ccff_head is registered, so it is loaded with pat(c) on the edge that
    // starts cycle c; hence the head generator looks at the next count.
    ccff_bist_pattern #(
        .CNT_W (CNT_W)
    ) u_head_pat (
        .idx     (cnt_d),
        .plen    (plen_d),
        .mode    (mode_d),
        .pat_bit (head_bit)
    );

    // A bit driven in cycle c reaches the tail during cycle c+CHAIN_LENGTH,
    // so the expected value at count c is pat(c - CHAIN_LENGTH).
    assign k_idx    = cnt_q - LEN_C;
    assign check_en = (state_q == SHIFT) && (cnt_q >= LEN_C);

    ccff_bist_pattern #(
        .CNT_W (CNT_W)
    ) u_exp_pat (
        .idx     (k_idx),
        .plen    (plen_q),
        .mode    (mode_q),
        .pat_bit (exp_bit)
    );

    assign mism   = check_en ? (bus.ccff_tail ^ {NUM_CHAINS{exp_bit}}) : '0;
    assign mask_d = mask_q | mism;

    // ------------------------------------------------------------------
    // Datapath: counter, head drive, error tracking, verdict
    // ------------------------------------------------------------------
    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            cnt_q  <= '0;
            mode_q <= MODE_PULSE;
            head_q <= '0;
            err_q  <= '0;
            mask_q <= '0;
            pass_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            mode_q <= mode_d;
            head_q <= (state_d == SHIFT) ? {NUM_CHAINS{head_bit}} : '0;

            if (accept) begin
                err_q  <= '0;
                mask_q <= '0;
                pass_q <= 1'b0;
            end else if (state_q == SHIFT) begin
                if (|mism) begin
                    mask_q <= mask_d;
                    if (err_q != '1) begin
                        err_q <= err_q + ERR_W'(1);
                    end
                end
                // Verdict uses mask_d so the final check cycle is included.
                if (state_d == REPORT) begin
                    pass_q <= (mask_d == '0);
                end
            end
        end
    end

    assign bus.ccff_head      = head_q;
    assign bus.busy           = (state_q == SHIFT);
    assign bus.done           = (state_q == REPORT);
    assign bus.pass           = pass_q;
    assign bus.err_count      = err_q;
    assign bus.err_chain_mask = mask_q;

endmodule

// File: tb/tb_ccff_bist.sv
// tb_ccff_bist
//   Directed bench for ccff_bist. Two instances share prog_clk:
//   dut_a : 2 chains, CHAIN_LENGTH 8, NUM_TAIL 2, ERR_W 16
//   dut_b : 1 chain,  CHAIN_LENGTH 8, NUM_TAIL 2, ERR_W 2
//   Each chain is an 8-bit shift register; faults (short chain, stuck tail)
//   are selected by bench variables.
module tb_ccff_bist;

    logic prog_clk = 1'b0;
    logic rst_a;
    logic rst_b;

    always #5 prog_clk = ~prog_clk;

    ccff_bist_if #(.NUM_CHAINS(2), .ERR_W(16)) ifa ();
    ccff_bist_if #(.NUM_CHAINS(1), .ERR_W(2))  ifb ();

    ccff_bist #(
        .NUM_CHAINS   (2),
        .CHAIN_LENGTH (8),
        .NUM_TAIL     (2),
        .ERR_W        (16)
    ) dut_a (
        .prog_clk   (prog_clk),
        .prog_reset (rst_a),
        .bus        (ifa)
    );

    ccff_bist #(
        .NUM_CHAINS   (1),
        .CHAIN_LENGTH (8),
        .NUM_TAIL     (2),
        .ERR_W        (2)
    ) dut_b (
        .prog_clk   (prog_clk),
        .prog_reset (rst_b),
        .bus        (ifb)
    );

    // Chain models
    logic [7:0] sr_a0 = '0;
    logic [7:0] sr_a1 = '0;
    logic [7:0] sr_b  = '0;
    bit         short_a0 = 1'b0;   // chain a0 only 7 flops long
    int         stuck_a1 = 0;      // 0 normal, 1 stuck-at-0, 2 stuck-at-1
    bit         stuck1_b = 1'b0;   // chain b tail stuck-at-1

    always @(posedge prog_clk) begin
        sr_a0 <= {sr_a0[6:0], ifa.ccff_head[0]};
        sr_a1 <= {sr_a1[6:0], ifa.ccff_head[1]};
        sr_b  <= {sr_b[6:0],  ifb.ccff_head[0]};
    end

    assign ifa.ccff_tail[0] = short_a0 ? sr_a0[6] : sr_a0[7];
    assign ifa.ccff_tail[1] = (stuck_a1 == 1) ? 1'b0 :
                              (stuck_a1 == 2) ? 1'b1 : sr_a1[7];
    assign ifb.ccff_tail[0] = stuck1_b ? 1'b1 : sr_b[7];

    int checks = 0;
    int errors = 0;

    // ------------------------------------------------------------------
    // Stimulus helpers (no comparisons inside)
    // ------------------------------------------------------------------
    task automatic start_a(input logic m);
        ifa.mode  = m;
        ifa.start = 1'b1;
        @(negedge prog_clk);
        ifa.start = 1'b0;
    endtask

    task automatic start_b(input logic m);
        ifb.mode  = m;
        ifb.start = 1'b1;
        @(negedge prog_clk);
        ifb.start = 1'b0;
    endtask

    // Counts busy cycles until done is seen (bounded); leaves the bench at
    // the negedge of the done cycle.
    task automatic wait_done(input bit sel_b, output int busy_cyc, output bit saw_done);
        busy_cyc = 0;
        saw_done = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (sel_b ? ifb.done : ifa.done) begin
                saw_done = 1'b1;
                break;
            end
            if (sel_b ? ifb.busy : ifa.busy) busy_cyc++;
            @(negedge prog_clk);
        end
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        rst_a = 1'b1;
        rst_b = 1'b1;
        ifa.start = 1'b0;
        ifa.mode  = 1'b0;
        ifb.start = 1'b0;
        ifb.mode  = 1'b0;
        repeat (3) @(negedge prog_clk);
        checks++; if (ifa.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", ifa.busy); end
        checks++; if (ifa.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", ifa.done); end
        checks++; if (ifa.pass !== 1'b0) begin errors++; $display("FAIL reset_pass: got %b expected 0", ifa.pass); end
        checks++; if (ifa.err_count !== 16'd0) begin errors++; $display("FAIL reset_err: got %0d expected 0", ifa.err_count); end
        checks++; if (ifa.err_chain_mask !== 2'b00) begin errors++; $display("FAIL reset_mask: got %b expected 00", ifa.err_chain_mask); end
        checks++; if (ifa.ccff_head !== 2'b00) begin errors++; $display("FAIL reset_head: got %b expected 00", ifa.ccff_head); end
        checks++; if (ifb.err_count !== 2'd0) begin errors++; $display("FAIL reset_err_b: got %0d expected 0", ifb.err_count); end
        rst_a = 1'b0;
        rst_b = 1'b0;
        repeat (20) @(negedge prog_clk);
    endtask

    task automatic test_pulse_timing();
        repeat (20) @(negedge prog_clk);
        start_a(1'b0);
        for (int c = 0; c < 11; c++) begin
            logic [1:0] exp_h;
            exp_h = (c == 0) ? 2'b11 : 2'b00;
            checks++; if (ifa.busy !== 1'b1) begin errors++; $display("FAIL pulse_busy c=%0d: got %b expected 1", c, ifa.busy); end
            checks++; if (ifa.done !== 1'b0) begin errors++; $display("FAIL pulse_done_early c=%0d: got %b expected 0", c, ifa.done); end
            checks++; if (ifa.ccff_head !== exp_h) begin errors++; $display("FAIL pulse_head c=%0d: got %b expected %b", c, ifa.ccff_head, exp_h); end
            @(negedge prog_clk);
        end
        checks++; if (ifa.done !== 1'b1) begin errors++; $display("FAIL pulse_done: got %b expected 1", ifa.done); end
        checks++; if (ifa.busy !== 1'b0) begin errors++; $display("FAIL pulse_busy_end: got %b expected 0", ifa.busy); end
        checks++; if (ifa.ccff_head !== 2'b00) begin errors++; $display("FAIL pulse_head_report: got %b expected 00", ifa.ccff_head); end
        checks++; if (ifa.pass !== 1'b1) begin errors++; $display("FAIL pulse_pass: got %b expected 1", ifa.pass); end
        checks++; if (ifa.err_count !== 16'd0) begin errors++; $display("FAIL pulse_err: got %0d expected 0", ifa.err_count); end
        checks++; if (ifa.err_chain_mask !== 2'b00) begin errors++; $display("FAIL pulse_mask: got %b expected 00", ifa.err_chain_mask); end
        @(negedge prog_clk);
        checks++; if (ifa.done !== 1'b0) begin errors++; $display("FAIL pulse_done_width: got %b expected 0", ifa.done); end
        repeat (3) @(negedge prog_clk);
        checks++; if (ifa.pass !== 1'b1) begin errors++; $display("FAIL pulse_pass_held: got %b expected 1", ifa.pass); end
    endtask

    task automatic test_alt_pattern();
        repeat (20) @(negedge prog_clk);
        start_a(1'b1);
        for (int c = 0; c < 18; c++) begin
            logic [1:0] exp_h;
            logic       cb;
            cb    = c[0];
            exp_h = (c < 8) ? {2{~cb}} : 2'b00;
            checks++; if (ifa.busy !== 1'b1) begin errors++; $display("FAIL alt_busy c=%0d: got %b expected 1", c, ifa.busy); end
            checks++; if (ifa.ccff_head !== exp_h) begin errors++; $display("FAIL alt_head c=%0d: got %b expected %b", c, ifa.ccff_head, exp_h); end
            @(negedge prog_clk);
        end
        checks++; if (ifa.done !== 1'b1) begin errors++; $display("FAIL alt_done: got %b expected 1", ifa.done); end
        checks++; if (ifa.pass !== 1'b1) begin errors++; $display("FAIL alt_pass: got %b expected 1", ifa.pass); end
        checks++; if (ifa.err_count !== 16'd0) begin errors++; $display("FAIL alt_err: got %0d expected 0", ifa.err_count); end
    endtask

    task automatic test_stuck_chain();
        int busy_cyc;
        bit saw;
        repeat (20) @(negedge prog_clk);
        stuck_a1 = 1;
        start_a(1'b0);
        wait_done(1'b0, busy_cyc, saw);
        checks++; if (saw !== 1'b1) begin errors++; $display("FAIL stuck_done_timeout: got %b expected 1", saw); end
        checks++; if (busy_cyc != 11) begin errors++; $display("FAIL stuck_len: got %0d expected 11", busy_cyc); end
        checks++; if (ifa.err_count !== 16'd1) begin errors++; $display("FAIL stuck_err: got %0d expected 1", ifa.err_count); end
        checks++; if (ifa.err_chain_mask !== 2'b10) begin errors++; $display("FAIL stuck_mask: got %b expected 10", ifa.err_chain_mask); end
        checks++; if (ifa.pass !== 1'b0) begin errors++; $display("FAIL stuck_pass: got %b expected 0", ifa.pass); end
        stuck_a1 = 0;
    endtask

    task automatic test_short_chain();
        int busy_cyc;
        bit saw;
        repeat (20) @(negedge prog_clk);
        short_a0 = 1'b1;
        start_a(1'b1);
        wait_done(1'b0, busy_cyc, saw);
        checks++; if (saw !== 1'b1) begin errors++; $display("FAIL short_done_timeout: got %b expected 1", saw); end
        checks++; if (busy_cyc != 18) begin errors++; $display("FAIL short_len: got %0d expected 18", busy_cyc); end
        checks++; if (ifa.err_count !== 16'd7) begin errors++; $display("FAIL short_err: got %0d expected 7", ifa.err_count); end
        checks++; if (ifa.err_chain_mask !== 2'b01) begin errors++; $display("FAIL short_mask: got %b expected 01", ifa.err_chain_mask); end
        checks++; if (ifa.pass !== 1'b0) begin errors++; $display("FAIL short_pass: got %b expected 0", ifa.pass); end
        short_a0 = 1'b0;
    endtask

    task automatic test_saturation();
        int busy_cyc;
        bit saw;
        repeat (20) @(negedge prog_clk);
        stuck1_b = 1'b1;
        start_b(1'b1);
        wait_done(1'b1, busy_cyc, saw);
        checks++; if (saw !== 1'b1) begin errors++; $display("FAIL sat_done_timeout: got %b expected 1", saw); end
        checks++; if (busy_cyc != 18) begin errors++; $display("FAIL sat_len: got %0d expected 18", busy_cyc); end
        checks++; if (ifb.err_count !== 2'd3) begin errors++; $display("FAIL sat_err: got %0d expected 3", ifb.err_count); end
        checks++; if (ifb.err_chain_mask !== 1'b1) begin errors++; $display("FAIL sat_mask: got %b expected 1", ifb.err_chain_mask); end
        checks++; if (ifb.pass !== 1'b0) begin errors++; $display("FAIL sat_pass: got %b expected 0", ifb.pass); end
        stuck1_b = 1'b0;
    endtask

    task automatic test_reset_mid();
        int busy_cyc;
        bit saw;
        int done_seen;
        repeat (20) @(negedge prog_clk);
        start_a(1'b1);
        repeat (5) @(negedge prog_clk);   // now in cycle c=5
        checks++; if (ifa.busy !== 1'b1) begin errors++; $display("FAIL rmid_busy_before: got %b expected 1", ifa.busy); end
        rst_a = 1'b1;
        @(negedge prog_clk);
        checks++; if (ifa.busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b expected 0", ifa.busy); end
        checks++; if (ifa.done !== 1'b0) begin errors++; $display("FAIL rmid_done: got %b expected 0", ifa.done); end
        checks++; if (ifa.ccff_head !== 2'b00) begin errors++; $display("FAIL rmid_head: got %b expected 00", ifa.ccff_head); end
        checks++; if (ifa.pass !== 1'b0) begin errors++; $display("FAIL rmid_pass: got %b expected 0", ifa.pass); end
        checks++; if (ifa.err_count !== 16'd0) begin errors++; $display("FAIL rmid_err: got %0d expected 0", ifa.err_count); end
        rst_a = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 25; i++) begin
            if (ifa.done === 1'b1) done_seen++;
            @(negedge prog_clk);
        end
        checks++; if (done_seen != 0) begin errors++; $display("FAIL rmid_no_done: got %0d pulses expected 0", done_seen); end
        // start and reset together: reset wins
        ifa.mode  = 1'b0;
        ifa.start = 1'b1;
        rst_a     = 1'b1;
        @(negedge prog_clk);
        ifa.start = 1'b0;
        rst_a     = 1'b0;
        checks++; if (ifa.busy !== 1'b0) begin errors++; $display("FAIL rst_start_busy: got %b expected 0", ifa.busy); end
        @(negedge prog_clk);
        checks++; if (ifa.busy !== 1'b0) begin errors++; $display("FAIL rst_start_busy2: got %b expected 0", ifa.busy); end
        // restart runs normally
        start_a(1'b0);
        wait_done(1'b0, busy_cyc, saw);
        checks++; if (saw !== 1'b1) begin errors++; $display("FAIL restart_done_timeout: got %b expected 1", saw); end
        checks++; if (busy_cyc != 11) begin errors++; $display("FAIL restart_len: got %0d expected 11", busy_cyc); end
        checks++; if (ifa.pass !== 1'b1) begin errors++; $display("FAIL restart_pass: got %b expected 1", ifa.pass); end
        checks++; if (ifa.err_count !== 16'd0) begin errors++; $display("FAIL restart_err: got %0d expected 0", ifa.err_count); end
    endtask

    task automatic test_start_ignored();
        int busy_cyc;
        bit saw;
        repeat (20) @(negedge prog_clk);
        start_a(1'b0);
        repeat (3) @(negedge prog_clk);   // now in cycle c=3
        ifa.mode  = 1'b1;
        ifa.start = 1'b1;
        @(negedge prog_clk);
        ifa.start = 1'b0;
        ifa.mode  = 1'b0;
        wait_done(1'b0, busy_cyc, saw);
        busy_cyc = busy_cyc + 4;
        checks++; if (saw !== 1'b1) begin errors++; $display("FAIL ign_done_timeout: got %b expected 1", saw); end
        checks++; if (busy_cyc != 11) begin errors++; $display("FAIL ign_len: got %0d expected 11", busy_cyc); end
        checks++; if (ifa.pass !== 1'b1) begin errors++; $display("FAIL ign_pass: got %b expected 1", ifa.pass); end
        checks++; if (ifa.err_count !== 16'd0) begin errors++; $display("FAIL ign_err: got %0d expected 0", ifa.err_count); end
        @(negedge prog_clk);
        checks++; if (ifa.busy !== 1'b0) begin errors++; $display("FAIL ign_no_restart: got %b expected 0", ifa.busy); end
    endtask

    initial begin
        test_reset();
        test_pulse_timing();
        test_alt_pattern();
        test_stuck_chain();
        test_short_chain();
        test_saturation();
        test_reset_mid();
        test_start_ignored();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
